// File: rtl/imm_extend_pkg.sv
// Shared definitions for the MIPS immediate-extension pipeline:
// mode codes, opcode/funct constants and the mode classification helper.
package imm_extend_pkg;

    typedef enum logic [2:0] {
        MODE_NONE   = 3'd0,
        MODE_ZERO   = 3'd1,
        MODE_SIGN   = 3'd2,
        MODE_LUI    = 3'd3,
        MODE_SHAMT  = 3'd4,
        MODE_BRANCH = 3'd5,
        MODE_JUMP   = 3'd6
    } imm_mode_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;

    // Classify an instruction word into its immediate-extension mode.
    function automatic imm_mode_e decode_mode(input logic [31:0] ir);
        imm_mode_e mode;
        case (ir[31:26])
            OP_SPECIAL: begin
                case (ir[5:0])
                    FN_SLL, FN_SRL, FN_SRA: mode = MODE_SHAMT;
                    default:                mode = MODE_NONE;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI:              mode = MODE_ZERO;
            OP_LUI:                                mode = MODE_LUI;
            OP_REGIMM, OP_BEQ, OP_BNE,
            OP_BLEZ, OP_BGTZ:                      mode = MODE_BRANCH;
            OP_J, OP_JAL:                          mode = MODE_JUMP;
            default:                               mode = MODE_SIGN;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/imm_extend_pipe_decode.sv
// Combinational decode and extension of a MIPS instruction immediate.
// Module name imm_extend_decode; DATA_W must be at least 32.
module imm_extend_decode
    import imm_extend_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic [31:0]       ir_i,
    output logic [DATA_W-1:0] imm_o,
    output imm_mode_e         mode_o
);

    logic [DATA_W-1:0] sign_ext_s;

    assign sign_ext_s = {{(DATA_W-16){ir_i[15]}}, ir_i[15:0]};

    // Select the extension rule for the decoded mode.
    always_comb begin
        mode_o = decode_mode(ir_i);
        imm_o  = '0;
        case (mode_o)
            MODE_ZERO:   imm_o = {{(DATA_W-16){1'b0}}, ir_i[15:0]};
            MODE_SIGN:   imm_o = sign_ext_s;
            // Shifting the 16-bit sign extension left by 16 equals
            // {imm,16'b0} sign-extended from bit 31 for any DATA_W >= 32.
            MODE_LUI:    imm_o = sign_ext_s << 5'd16;
            MODE_SHAMT:  imm_o = {{(DATA_W-5){1'b0}}, ir_i[10:6]};
            MODE_BRANCH: imm_o = sign_ext_s << BR_SHIFT;
            MODE_JUMP:   imm_o = {{(DATA_W-28){1'b0}}, ir_i[25:0], 2'b00};
            MODE_NONE:   imm_o = '0;
            default:     imm_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Handshaked immediate-extension stage: one output register, plus an
// optional skid entry enabled by the macro IMM_EXTEND_SKID_EN which makes
// in_ready a registered signal independent of out_ready.
module imm_extend_pipe
    import imm_extend_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_ir,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [2:0]        out_mode
);

    logic [DATA_W-1:0] dec_imm_s;
    imm_mode_e         dec_mode_s;
    logic              accept_s;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_imm_q,   out_imm_d;
    imm_mode_e         out_mode_q,  out_mode_d;

    imm_extend_decode #(
        .DATA_W   (DATA_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_decode (
        .ir_i   (in_ir),
        .imm_o  (dec_imm_s),
        .mode_o (dec_mode_s)
    );

    assign accept_s  = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_imm   = out_imm_q;
    assign out_mode  = out_mode_q;

`ifdef IMM_EXTEND_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_imm_q,   skid_imm_d;
    imm_mode_e         skid_mode_q,  skid_mode_d;
    logic              in_ready_q,   in_ready_d;

    // rst/flush gate the registered ready; out_ready never reaches it.
    assign in_ready = in_ready_q && !rst && !flush;

    // Next state for output and skid entries; skid drains first to keep order.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_mode_d   = out_mode_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_mode_d  = skid_mode_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_mode_d   = skid_mode_q;
                skid_valid_d = accept_s;
                skid_imm_d   = dec_imm_s;
                skid_mode_d  = dec_mode_s;
            end else if (accept_s) begin
                out_valid_d  = 1'b1;
                out_imm_d    = dec_imm_s;
                out_mode_d   = dec_mode_s;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (accept_s) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm_s;
            skid_mode_d  = dec_mode_s;
        end else begin
            skid_valid_d = skid_valid_q;
        end
        in_ready_d = !skid_valid_d;
    end

    // Output, skid and ready registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_mode_q   <= MODE_NONE;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_mode_q  <= MODE_NONE;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_mode_q   <= out_mode_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_mode_q  <= skid_mode_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    // Ready whenever the single output register is empty or draining.
    assign in_ready = !rst && !flush && (!out_valid_q || out_ready);

    // Next state for the single output register.
    always_comb begin
        out_valid_d = out_valid_q;
        out_imm_d   = out_imm_q;
        out_mode_d  = out_mode_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            out_imm_d   = dec_imm_s;
            out_mode_d  = dec_mode_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_imm_q   <= '0;
            out_mode_q  <= MODE_NONE;
        end else begin
            out_valid_q <= out_valid_d;
            out_imm_q   <= out_imm_d;
            out_mode_q  <= out_mode_d;
        end
    end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe (DATA_W=32, BR_SHIFT=2).
module tb_imm_extend_pipe;

    localparam int DW = 32;
`ifdef IMM_EXTEND_SKID_EN
    localparam logic SKID = 1'b1;
`else
    localparam logic SKID = 1'b0;
`endif

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  mode;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]   in_ir;
    logic [DW-1:0] out_imm;
    logic [2:0]    out_mode;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    localparam int NV = 15;
    logic [31:0] vec_ir   [NV] = '{32'h2008FFFF, 32'h3508FFFF, 32'h3C081234, 32'h00084080,
                                   32'h01084020, 32'h1000FFFF, 32'h08000010, 32'h31088000,
                                   32'h8C88FFF0, 32'h04010004, 32'h0FFFFFFF, 32'h000847C3,
                                   32'h3C088000, 32'h18000001, 32'h3908ABCD};
    logic [31:0] vec_imm  [NV] = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h12340000, 32'h00000002,
                                   32'h00000000, 32'hFFFFFFFC, 32'h00000040, 32'h00008000,
                                   32'hFFFFFFF0, 32'h00000010, 32'h0FFFFFFC, 32'h0000001F,
                                   32'h80000000, 32'h00000004, 32'h0000ABCD};
    logic [2:0]  vec_mode [NV] = '{3'd2, 3'd1, 3'd3, 3'd4, 3'd0, 3'd5, 3'd6, 3'd1,
                                   3'd2, 3'd5, 3'd6, 3'd4, 3'd3, 3'd5, 3'd1};

    imm_extend_pipe #(.DATA_W(DW), .BR_SHIFT(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ir     (in_ir),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_mode  (out_mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented result with the queue head; pop on consume.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !flush && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result actual imm=%h mode=%0d expected none", out_imm, out_mode);
            end else begin
                e = exp_q[0];
                if (out_imm !== e.imm || out_mode !== e.mode) begin
                    errors++;
                    $display("FAIL result actual imm=%h mode=%0d expected imm=%h mode=%0d",
                             out_imm, out_mode, e.imm, e.mode);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Present one instruction until accepted; push its expected result on accept.
    task automatic send(input logic [31:0] ir, input logic [31:0] imm, input logic [2:0] mode,
                        output int waits);
        exp_t e;
        e.imm  = imm;
        e.mode = mode;
        waits  = 0;
        in_valid = 1'b1;
        in_ir    = ir;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
            waits++;
        end
        chk("send_timeout", 64'(waits), 64'd0);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for every expected result to be delivered.
    task automatic drain();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int w;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ir = 32'h0; out_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_in_rst", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_imm", 64'(out_imm), 64'd0);
        chk("rst_mode", 64'(out_mode), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Single transfer: result exactly one cycle after accept.
        out_ready = 1'b1;
        send(vec_ir[0], vec_imm[0], vec_mode[0], w);
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_valid", 64'(out_valid), 64'd1);
        chk("latency_imm", 64'(out_imm), 64'hFFFFFFFF);
        drain();

        // Full-throughput stream of all vectors.
        for (int i = 0; i < NV; i++) begin
            send(vec_ir[i], vec_imm[i], vec_mode[i], w);
            chk("throughput_wait", 64'(w), 64'd0);
        end
        in_valid = 1'b0;
        drain();

        // Three back-to-back with output stalled for three cycles.
        out_ready = 1'b0;
        fork
            begin
                send(vec_ir[2], vec_imm[2], vec_mode[2], w);
                send(vec_ir[5], vec_imm[5], vec_mode[5], w);
                send(vec_ir[6], vec_imm[6], vec_mode[6], w);
                in_valid = 1'b0;
            end
            begin
                @(negedge clk);
                chk("stall_ready0", 64'(in_ready), 64'd1);
                @(negedge clk);
                chk("stall_ready1", 64'(in_ready), 64'(SKID));
                @(negedge clk);
                chk("stall_ready2", 64'(in_ready), 64'd0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Flush while stalled, with out_ready high during the flush cycle.
        out_ready = 1'b0;
        send(vec_ir[1], vec_imm[1], vec_mode[1], w);
        if (SKID) send(vec_ir[3], vec_imm[3], vec_mode[3], w);
        in_valid  = 1'b0;
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_ready", 64'(in_ready), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", 64'(out_valid), 64'd0);
        repeat (4) @(posedge clk);
        #1;

        // Reset in the middle of a stall.
        out_ready = 1'b0;
        send(vec_ir[7], vec_imm[7], vec_mode[7], w);
        if (SKID) send(vec_ir[8], vec_imm[8], vec_mode[8], w);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 64'(in_ready), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_imm", 64'(out_imm), 64'd0);
        chk("midrst_mode", 64'(out_mode), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(vec_ir[10], vec_imm[10], vec_mode[10], w);
        chk("resume_wait", 64'(w), 64'd0);
        in_valid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound in case a handshake never completes.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
